mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit_pkg.sv | 29 ++
 rtl/mul_div_unit_if.sv | 27 ++
 rtl/mdu_datapath.sv | 93 +++++++++
 rtl/mul_div_unit.sv | 90 +++++++++
 tb/tb_mul_div_unit.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - shared MIPS op/state encodings and helpers for the multiply/divide unit
package mul_div_unit_pkg;

  localparam int MDU_XLEN = 32;

  // HI/LO operation codes as decoded by the control unit
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CALC   = 2'b01,
    ST_FINISH = 2'b10
  } mdu_state_e;

  function automatic logic op_is_div(input mdu_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input mdu_op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - request/result bundle between the control unit and the multiply/divide unit
interface mul_div_unit_if #(
  parameter int XLEN = 32
) ();

  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] in0;
  logic [XLEN-1:0] in1;
  logic            mthi;
  logic            mtlo;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] HI;
  logic [XLEN-1:0] LO;

  modport master (
    output start, op, in0, in1, mthi, mtlo,
    input  busy, done, HI, LO
  );

  modport slave (
    input  start, op, in0, in1, mthi, mtlo,
    output busy, done, HI, LO
  );

endinterface

// File: rtl/mdu_datapath.sv
// rtl/mdu_datapath.sv - radix-2 shift-add multiply / restoring divide datapath with sign correction
module mdu_datapath
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            step_i,
  input  mdu_op_e         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  mdu_op_e           op_q;
  logic [XLEN-1:0]   mag_a_q;
  logic [XLEN-1:0]   mag_b_q;
  logic              neg_a_q;
  logic              neg_b_q;
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_d;

  logic              sgn_in;
  logic [XLEN-1:0]   mag_a_d;
  logic [XLEN-1:0]   mag_b_d;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] prod_fix;

  assign sgn_in  = op_is_signed(op_i);
  assign mag_a_d = (sgn_in && a_i[XLEN-1]) ? -a_i : a_i;
  assign mag_b_d = (sgn_in && b_i[XLEN-1]) ? -b_i : b_i;

  // Next accumulator: one shift-add step (multiply) or one shift-subtract step (divide)
  always_comb begin
    acc_d    = acc_q;
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
    div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, mag_b_q};
    if (load_i) begin
      acc_d = op_is_div(op_i) ? {{XLEN{1'b0}}, mag_a_d} : {{XLEN{1'b0}}, mag_b_d};
    end else if (step_i) begin
      if (!op_is_div(op_q)) begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
      end else if (!div_diff[XLEN]) begin
        acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_d = {acc_q[2*XLEN-2:0], 1'b0};
      end
    end
  end

  // Operand capture on accept, accumulator update every cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q    <= OP_MULT;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      acc_q   <= '0;
    end else begin
      if (load_i) begin
        op_q    <= op_i;
        mag_a_q <= mag_a_d;
        mag_b_q <= mag_b_d;
        neg_a_q <= sgn_in && a_i[XLEN-1];
        neg_b_q <= sgn_in && b_i[XLEN-1];
      end
      acc_q <= acc_d;
    end
  end

  assign prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;

  // Sign-corrected result; divide by zero returns all-ones quotient and the original dividend
  always_comb begin
    hi_o = prod_fix[2*XLEN-1:XLEN];
    lo_o = prod_fix[XLEN-1:0];
    if (op_is_div(op_q)) begin
      if (mag_b_q == '0) begin
        lo_o = '1;
        hi_o = neg_a_q ? -mag_a_q : mag_a_q;
      end else begin
        lo_o = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        hi_o = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - MIPS HI/LO multiply/divide unit: sequencer, iteration counter and HI/LO registers
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rst_n,
  mul_div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  mdu_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;

  logic            accept;
  logic            step;
  logic [XLEN-1:0] res_hi;
  logic [XLEN-1:0] res_lo;

  assign accept = (state_q == ST_IDLE) && bus.start;
  assign step   = (state_q == ST_CALC);

  mdu_datapath #(
    .XLEN (XLEN)
  ) u_datapath (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept),
    .step_i (step),
    .op_i   (mdu_op_e'(bus.op)),
    .a_i    (bus.in0),
    .b_i    (bus.in1),
    .hi_o   (res_hi),
    .lo_o   (res_lo)
  );

  // Sequencer: accept in IDLE, iterate XLEN times, commit to HI/LO and pulse done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q <= ST_CALC;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            if (bus.mthi) hi_q <= bus.in0;
            if (bus.mtlo) lo_q <= bus.in0;
          end
        end
        ST_CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_q <= ST_FINISH;
        end
        ST_FINISH: begin
          hi_q    <= res_hi;
          lo_q    <= res_lo;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed scoreboard bench for the multiply/divide unit
module tb_mul_div_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [63:0] sb[$];
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mul_div_unit_if #(.XLEN(32)) bus ();

  mul_div_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int q;
    int r;
    case (op)
      2'b00: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      2'b01: return {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Issue one op at a negedge, watch it to completion, compare against the scoreboard.
  // Returns positioned at the negedge of the done cycle.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] expv, input bit gate_test);
    int cyc;
    bit busy_ok;
    bit stable_ok;
    logic [63:0] e;
    bus.op = op; bus.in0 = a; bus.in1 = b; bus.start = 1'b1;
    sb.push_back(expv);
    @(negedge clk);
    bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
    cyc = 0; busy_ok = 1'b1; stable_ok = 1'b1;
    while (bus.done !== 1'b1 && cyc < 40) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.HI !== exp_hi || bus.LO !== exp_lo) stable_ok = 1'b0;
      if (gate_test && cyc == 5) begin
        bus.start = 1'b1; bus.mthi = 1'b1; bus.mtlo = 1'b1;
        bus.in0 = ~a; bus.in1 = 32'h0; bus.op = 2'b11;
      end
      if (gate_test && cyc == 7) begin
        bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, " busy during op"}, {63'h0, busy_ok}, 64'h1);
    check({tag, " done latency"}, 64'(cyc), 64'd33);
    check({tag, " busy cleared at done"}, {63'h0, bus.busy}, 64'h0);
    if (gate_test) check({tag, " HI/LO stable while busy"}, {63'h0, stable_ok}, 64'h1);
    e = sb.pop_front();
    check({tag, " HI"}, {32'h0, bus.HI}, {32'h0, e[63:32]});
    check({tag, " LO"}, {32'h0, bus.LO}, {32'h0, e[31:0]});
    exp_hi = e[63:32];
    exp_lo = e[31:0];
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    bit          done_seen;
    checks = 0; errors = 0;
    exp_hi = 32'h0; exp_lo = 32'h0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.in0 = 32'h0; bus.in1 = 32'h0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", {63'h0, bus.busy}, 64'h0);
    check("reset done", {63'h0, bus.done}, 64'h0);
    check("reset HI", {32'h0, bus.HI}, 64'h0);
    check("reset LO", {32'h0, bus.LO}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // IDLE writes to HI/LO
    bus.in0 = 32'h12345678; bus.mthi = 1'b1;
    @(negedge clk);
    bus.mthi = 1'b0;
    check("mthi HI", {32'h0, bus.HI}, 64'h12345678);
    check("mthi LO untouched", {32'h0, bus.LO}, 64'h0);
    bus.in0 = 32'hCAFEF00D; bus.mthi = 1'b1; bus.mtlo = 1'b1;
    @(negedge clk);
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    check("mthi+mtlo HI", {32'h0, bus.HI}, 64'hCAFEF00D);
    check("mthi+mtlo LO", {32'h0, bus.LO}, 64'hCAFEF00D);
    exp_hi = 32'hCAFEF00D; exp_lo = 32'hCAFEF00D;

    // MULTU max*max, start beats a simultaneous mthi/mtlo
    bus.mthi = 1'b1; bus.mtlo = 1'b1;
    run_op("MULTU max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0);
    @(negedge clk);
    check("MULTU done one cycle", {63'h0, bus.done}, 64'h0);

    run_op("MULT -3*7", 2'b00, 32'hFFFFFFFD, 32'h7, 64'hFFFFFFFF_FFFFFFEB, 1'b0);
    @(negedge clk);
    run_op("DIV -7/2", 2'b10, 32'hFFFFFFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
    @(negedge clk);
    run_op("DIVU 100/0", 2'b11, 32'd100, 32'h0, 64'h00000064_FFFFFFFF, 1'b0);
    @(negedge clk);
    run_op("DIV min/-1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0);
    @(negedge clk);
    run_op("DIV -9/0", 2'b10, 32'hFFFFFFF7, 32'h0, 64'hFFFFFFF7_FFFFFFFF, 1'b0);
    @(negedge clk);

    // start/mthi/mtlo while busy must be ignored
    run_op("gated DIVU", 2'b11, 32'd1000, 32'd7, 64'h00000006_0000008E, 1'b1);
    @(negedge clk);
    check("gated no extra done", {63'h0, bus.done}, 64'h0);
    check("gated no restart", {63'h0, bus.busy}, 64'h0);

    // Back-to-back: new start issued in the done cycle
    run_op("b2b MULT", 2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0);
    run_op("b2b DIV", 2'b10, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0);
    @(negedge clk);

    // Random ops against the reference model
    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 3) ? 32'h0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000)));
      run_op($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb), 1'b0);
      @(negedge clk);
    end

    // Reset at iteration 10 abandons the op
    bus.op = 2'b01; bus.in0 = 32'h1234; bus.in1 = 32'h5678; bus.start = 1'b1;
    sb.push_back(64'h0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    void'(sb.pop_back());
    check("midreset busy", {63'h0, bus.busy}, 64'h0);
    check("midreset HI", {32'h0, bus.HI}, 64'h0);
    check("midreset LO", {32'h0, bus.LO}, 64'h0);
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) done_seen = 1'b1;
    end
    check("midreset no done", {63'h0, done_seen}, 64'h0);
    exp_hi = 32'h0; exp_lo = 32'h0;

    run_op("post-reset MULTU", 2'b01, 32'd12345, 32'd6789, model(2'b01, 32'd12345, 32'd6789), 1'b0);
    @(negedge clk);
    check("scoreboard drained", 64'(sb.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
